// File: rtl/cva6_ptw_sv32_pkg.sv
// Shared types and constants for the Sv32 page-table walker.
// The PTE layout and the TLB update word match what cva6_tlb_sv32 consumes.
package cva6_ptw_sv32_pkg;

    localparam int unsigned PTE_SIZE   = 4;
    localparam int unsigned PAGE_SHIFT = 12;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_sv32_t;

    typedef struct packed {
        logic        valid;
        logic        is_4m;
        logic [19:0] vpn;
        logic [8:0]  asid;
        pte_sv32_t   pte;
    } tlb_update_sv32_t;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        DRAIN
    } walk_state_e;

    // Physical address of entry 'idx' in the page table rooted at page 'ppn'
    function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] idx);
        return ({12'b0, ppn} << PAGE_SHIFT) + ({24'b0, idx} * 34'(PTE_SIZE));
    endfunction

endpackage

// File: rtl/cva6_ptw_pte_check.sv
// Combinational classification of one Sv32 PTE at a given walk level.
// Optional macro PTW_AD_CHECK_EN: leaf PTEs with A=0 are flagged as faults.
import cva6_ptw_sv32_pkg::*;

module cva6_ptw_pte_check (
    input  logic [31:0] pte,
    input  logic        level,
    output logic        invalid,
    output logic        leaf,
    output logic        misaligned,
    output logic        a_fault
);

    pte_sv32_t entry;
    logic      unused_bits;

    assign entry       = pte_sv32_t'(pte);
    assign unused_bits = ^{entry.ppn1, entry.rsw, entry.d, entry.g, entry.u};

    // Decode validity, leaf-ness and superpage alignment from the PTE flags
    always_comb begin
        invalid    = !entry.v || (!entry.r && entry.w);
        leaf       = entry.r || entry.x;
        misaligned = level && leaf && (entry.ppn0 != 10'd0);
`ifdef PTW_AD_CHECK_EN
        a_fault    = leaf && !entry.a;
`else
        a_fault    = 1'b0 & entry.a;
`endif
    end

endmodule

// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 two-level hardware page-table walker feeding cva6_tlb_sv32.
// Optional macro PTW_AD_CHECK_EN: leaf PTEs with A=0 fault instead of updating.
import cva6_ptw_sv32_pkg::*;

module cva6_ptw_sv32_walker #(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned PA_WIDTH   = 34
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    input  logic [21:0]           satp_ppn_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [PA_WIDTH-1:0]   mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [62:0]           update_o,
    output logic                  page_fault_o,
    output logic                  busy_o
);

    walk_state_e           state;
    logic [19:0]           vpn;
    logic [ASID_WIDTH-1:0] asid;
    logic [PA_WIDTH-1:0]   mem_addr;
    tlb_update_sv32_t      update;
    logic                  fault;
    logic                  chk_invalid;
    logic                  chk_leaf;
    logic                  chk_misaligned;
    logic                  chk_a_fault;
    logic                  unused_vaddr;

    assign unused_vaddr = ^miss_vaddr_i[11:0];

    cva6_ptw_pte_check u_pte_check (
        .pte        (mem_rdata_i),
        .level      (state == L1_WAIT),
        .invalid    (chk_invalid),
        .leaf       (chk_leaf),
        .misaligned (chk_misaligned),
        .a_fault    (chk_a_fault)
    );

    // Outputs derived from the state register and the registered pulses
    always_comb begin
        miss_ready_o = (state == IDLE);
        busy_o       = (state != IDLE);
        mem_req_o    = (state == L1_REQ) || (state == L0_REQ);
        mem_addr_o   = mem_addr;
        update_o     = update;
        page_fault_o = fault;
    end

    // Walk sequencing; update and fault pulses are cleared every cycle unless set
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            vpn      <= '0;
            asid     <= '0;
            mem_addr <= '0;
            update   <= '0;
            fault    <= 1'b0;
        end else begin
            update <= '0;
            fault  <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_valid_i && !flush_i) begin
                        vpn      <= miss_vaddr_i[31:12];
                        asid     <= miss_asid_i;
                        mem_addr <= PA_WIDTH'(pte_addr(satp_ppn_i, miss_vaddr_i[31:22]));
                        state    <= L1_REQ;
                    end
                end
                L1_REQ, L0_REQ: begin
                    if (mem_gnt_i) begin
                        if (flush_i) state <= DRAIN;
                        else         state <= (state == L1_REQ) ? L1_WAIT : L0_WAIT;
                    end else if (flush_i) begin
                        state <= IDLE;
                    end
                end
                L1_WAIT: begin
                    if (flush_i) begin
                        state <= mem_rvalid_i ? IDLE : DRAIN;
                    end else if (mem_rvalid_i) begin
                        if (chk_invalid) begin
                            fault <= 1'b1;
                            state <= IDLE;
                        end else if (chk_leaf) begin
                            if (chk_misaligned || chk_a_fault) begin
                                fault <= 1'b1;
                            end else begin
                                update <= '{valid: 1'b1, is_4m: 1'b1, vpn: vpn,
                                            asid: 9'(asid), pte: pte_sv32_t'(mem_rdata_i)};
                            end
                            state <= IDLE;
                        end else begin
                            mem_addr <= PA_WIDTH'(pte_addr(mem_rdata_i[31:10], vpn[9:0]));
                            state    <= L0_REQ;
                        end
                    end
                end
                L0_WAIT: begin
                    if (flush_i) begin
                        state <= mem_rvalid_i ? IDLE : DRAIN;
                    end else if (mem_rvalid_i) begin
                        if (chk_invalid || !chk_leaf || chk_a_fault) begin
                            fault <= 1'b1;
                        end else begin
                            update <= '{valid: 1'b1, is_4m: 1'b0, vpn: vpn,
                                        asid: 9'(asid), pte: pte_sv32_t'(mem_rdata_i)};
                        end
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_ptw_sv32_walker.sv
// Directed self-checking bench for cva6_ptw_sv32_walker.
// Optional macro PTW_AD_CHECK_EN selects the expected result of the A=0 leaf step.
module tb_cva6_ptw_sv32_walker;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_vaddr;
    logic [0:0]  miss_asid;
    logic [21:0] satp_ppn;
    logic        mem_req;
    logic        mem_gnt;
    logic [33:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [62:0] update;
    logic        page_fault;
    logic        busy;

    int total;
    int bad;

    cva6_ptw_sv32_walker #(
        .ASID_WIDTH (1),
        .PA_WIDTH   (34)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .miss_valid_i (miss_valid),
        .miss_ready_o (miss_ready),
        .miss_vaddr_i (miss_vaddr),
        .miss_asid_i  (miss_asid),
        .satp_ppn_i   (satp_ppn),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .update_o     (update),
        .page_fault_o (page_fault),
        .busy_o       (busy)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [62:0] observed, input logic [62:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a miss for one cycle; outputs are sampled on the falling edge
    task automatic apply_stimulus(input logic [31:0] vaddr, input logic asid);
        @(negedge clk);
        check_output("ready_before_miss", 63'(miss_ready), 63'(1));
        miss_vaddr = vaddr;
        miss_asid  = asid;
        miss_valid = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, grant it, then return data
    task automatic mem_xact(input string tag, input logic [33:0] exp_addr, input logic [31:0] data);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_req"}, 63'(mem_req), 63'(1));
        check_output({tag, "_addr"}, 63'(mem_addr), 63'(exp_addr));
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_output({tag, "_req_dropped"}, 63'(mem_req), 63'(0));
        mem_rdata  = data;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    function automatic logic [62:0] upd(input logic is_4m, input logic [19:0] vpn,
                                        input logic [8:0] asid, input logic [31:0] pte);
        return {1'b1, is_4m, vpn, asid, pte};
    endfunction

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        miss_valid = 1'b0;
        miss_vaddr = '0;
        miss_asid  = '0;
        satp_ppn   = 22'h00010;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        @(negedge clk);
        check_output("rst_update", update, 63'(0));
        check_output("rst_fault", 63'(page_fault), 63'(0));
        check_output("rst_req", 63'(mem_req), 63'(0));
        check_output("rst_busy", 63'(busy), 63'(0));
        check_output("rst_ready", 63'(miss_ready), 63'(1));
        rst_n = 1'b1;

        $display("[TB] 4K walk");
        apply_stimulus(32'h00403000, 1'b1);
        check_output("4k_busy", 63'(busy), 63'(1));
        mem_xact("4k_l1", 34'h10004, 32'h00008001);
        check_output("4k_update_early", update, 63'(0));
        mem_xact("4k_l0", 34'h2000C, 32'h000300CF);
        check_output("4k_update", update, upd(1'b0, 20'h00403, 9'd1, 32'h000300CF));
        check_output("4k_fault", 63'(page_fault), 63'(0));
        @(negedge clk);
        check_output("4k_update_clear", update, 63'(0));
        check_output("4k_idle", 63'(miss_ready), 63'(1));

        $display("[TB] 4M walk");
        apply_stimulus(32'h00403000, 1'b1);
        mem_xact("4m_l1", 34'h10004, 32'h040000CF);
        check_output("4m_update", update, upd(1'b1, 20'h00403, 9'd1, 32'h040000CF));
        @(negedge clk);
        check_output("4m_no_second_req", 63'(mem_req), 63'(0));
        check_output("4m_update_clear", update, 63'(0));

        $display("[TB] misaligned superpage");
        apply_stimulus(32'h00403000, 1'b1);
        mem_xact("mis_l1", 34'h10004, 32'h040004CF);
        check_output("mis_fault", 63'(page_fault), 63'(1));
        check_output("mis_update", update, 63'(0));
        @(negedge clk);
        check_output("mis_fault_clear", 63'(page_fault), 63'(0));
        check_output("mis_idle", 63'(miss_ready), 63'(1));

        $display("[TB] invalid PTEs");
        apply_stimulus(32'h00403000, 1'b0);
        mem_xact("inv_l1", 34'h10004, 32'h00000000);
        check_output("inv_l1_fault", 63'(page_fault), 63'(1));
        apply_stimulus(32'h00403000, 1'b0);
        mem_xact("nl_l1", 34'h10004, 32'h00008001);
        mem_xact("nl_l0", 34'h2000C, 32'h00008001);
        check_output("nl_l0_fault", 63'(page_fault), 63'(1));
        check_output("nl_l0_update", update, 63'(0));

        $display("[TB] flush during L0 wait");
        apply_stimulus(32'h00403000, 1'b1);
        mem_xact("fl_l1", 34'h10004, 32'h00008001);
        check_output("fl_l0_req", 63'(mem_req), 63'(1));
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("fl_drain_busy", 63'(busy), 63'(1));
        @(negedge clk);
        @(negedge clk);
        mem_rdata  = 32'h000300CF;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_output("fl_ready", 63'(miss_ready), 63'(1));
        check_output("fl_update", update, 63'(0));
        check_output("fl_fault", 63'(page_fault), 63'(0));

        $display("[TB] flush before grant");
        apply_stimulus(32'h00403000, 1'b1);
        check_output("flr_req", 63'(mem_req), 63'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("flr_req_dropped", 63'(mem_req), 63'(0));
        check_output("flr_ready", 63'(miss_ready), 63'(1));

        $display("[TB] flush with simultaneous miss");
        flush      = 1'b1;
        miss_valid = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        miss_valid = 1'b0;
        check_output("flm_req", 63'(mem_req), 63'(0));
        check_output("flm_busy", 63'(busy), 63'(0));

        $display("[TB] leaf with A=0");
        apply_stimulus(32'h00403000, 1'b1);
        mem_xact("ad_l1", 34'h10004, 32'h00008001);
        mem_xact("ad_l0", 34'h2000C, 32'h0003008F);
`ifdef PTW_AD_CHECK_EN
        check_output("ad_fault", 63'(page_fault), 63'(1));
        check_output("ad_update", update, 63'(0));
`else
        check_output("ad_fault", 63'(page_fault), 63'(0));
        check_output("ad_update", update, upd(1'b0, 20'h00403, 9'd1, 32'h0003008F));
`endif
        @(negedge clk);
        check_output("ad_idle", 63'(miss_ready), 63'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_ptw_sv32_walker.md
Name: cva6_ptw_sv32_walker

Overview:
- Sv32 hardware page-table walker; the producer side of the TLB update interface consumed by cva6_tlb_sv32.
- Accepts a TLB miss (vaddr, asid) and walks the two-level page table over a req/gnt/rvalid memory port.
- On success, emits a single-cycle update word in the exact format the TLB consumes; on failure, signals a page fault.
- Honours TLB flush mid-walk so a stale translation is never installed.

Parameters:
- ASID_WIDTH, 1, width of lookup ASID; zero-extended to 9 bits in update_o.
- PA_WIDTH, 34, physical address width of mem_addr_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  sfence/TLB flush; aborts walk
- miss_valid_i  in  1  miss request valid
- miss_ready_o  out  1  walker idle, can accept miss
- miss_vaddr_i  in  32  faulting virtual address
- miss_asid_i  in  ASID_WIDTH  ASID of miss
- satp_ppn_i  in  22  root page-table PPN
- mem_req_o  out  1  PTE read request
- mem_gnt_i  in  1  request accepted
- mem_addr_o  out  PA_WIDTH  PTE physical address
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  PTE data
- update_o  out  63  {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]} to TLB update_i
- page_fault_o  out  1  one-cycle fault pulse
- busy_o  out  1  walk in progress

Behaviour:
- Reset (async, rst_ni=0): state IDLE; update_o=0, page_fault_o=0, mem_req_o=0, busy_o=0, miss_ready_o=1; latched vaddr/asid cleared.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DRAIN.
- IDLE: miss_ready_o=1. miss_valid_i && !flush_i latches vaddr and asid, then goes to L1_REQ. Flush in the same cycle wins; the miss is not accepted.
- L1_REQ: mem_req_o=1, mem_addr_o = {satp_ppn_i,12'b0} + vpn1*4. Request and address held stable until mem_gnt_i; on grant go to L1_WAIT.
- L1_WAIT, on mem_rvalid_i, classify the PTE as follows:
  - Invalid (V=0, or R=0 && W=1): fault.
  - Leaf (R|X): if ppn0 (pte[19:10]) != 0, misaligned-superpage fault; else 4M update.
  - Otherwise pointer: next address = {pte[31:10],12'b0} + vpn0*4, go to L0_REQ.
- L0_REQ / L0_WAIT: same handshake as level 1.
  - Invalid or non-leaf PTE: fault.
  - Leaf: 4K update.
- Update and fault pulses are registered and last exactly one cycle; both return to IDLE the following cycle.
  - update_o[62]=1, [61]=is_4M, [60:41]=vpn, [40:32]=zero-extended asid, [31:0]=raw PTE.
  - update_o is 0 whenever no pulse is active.
- Latency: with gnt and rvalid each in the cycle after req/grant, a 4K walk pulses update_o 5 cycles after miss accept; a 4M walk pulses after 3.
- Flush:
  - In *_REQ before grant: drop mem_req_o, go to IDLE.
  - In *_WAIT: go to DRAIN.
  - On the grant cycle: go to DRAIN.
  - DRAIN waits for mem_rvalid_i, discards the data, then goes to IDLE. No update or fault is issued.
- Only one outstanding memory request at a time. mem_rvalid_i in IDLE/REQ states is ignored.
- busy_o = (state != IDLE). Address arithmetic is done in PA_WIDTH; no overflow wrap is expected.

Optional Feature:
- Macro: PTW_AD_CHECK_EN.
- Defined: a leaf PTE with A (bit 6) = 0 raises page_fault_o instead of an update.
- Undefined: the A bit is ignored and the PTE is passed through unchanged.

Decomposition:
- Package cva6_ptw_sv32_pkg holds:
  - pte_sv32_t struct (ppn1[11:0], ppn0[9:0], rsw, d, a, g, u, x, w, r, v).
  - tlb_update_sv32_t struct (63 bits, as above).
  - walk_state_e enum.
  - Constants PTE_SIZE=4 and PAGE_SHIFT=12.
- One sub-module: cva6_ptw_pte_check. It is combinational and takes PTE + level, returning {invalid, leaf, misaligned, a_fault}.

Test Plan:
1. 4K walk: satp_ppn=0x00010, vaddr=0x00403000, asid=1.
   - Expect mem_addr 0x10004; respond 0x00008001.
   - Expect mem_addr 0x2000C; respond 0x000300CF.
   - Expect one-cycle update_o={1,0,0x00403,9'd1,0x000300CF}.
2. 4M walk: same vaddr; L1 responds 0x040000CF. Expect a single request, then update_o is_4M=1 with pte 0x040000CF.
3. Misaligned superpage: L1 responds 0x040004CF. Expect page_fault_o pulse, update_o=0, return to IDLE.
4. Invalid PTE: L1 responds 0x00000000 → fault. L0 responds 0x00008001 (non-leaf) → fault.
5. Flush during L0_WAIT: flush_i=1 one cycle, rvalid arrives 3 cycles later with 0x000300CF. Expect no update, no fault, miss_ready_o=1 the cycle after rvalid.
6. Flush with simultaneous miss_valid_i in IDLE: miss not accepted, mem_req_o stays 0. With PTW_AD_CHECK_EN, leaf 0x0003008F (A=0) → fault.
